// File: rtl/data_mem_ctrl_if.sv
// rtl/data_mem_ctrl_if.sv - external data-memory bus between the controller and memory
//
// Purpose: bundles the single-outstanding request/ack memory bus.
// Signals:
//   mem_req    controller -> memory  request, high for the whole access
//   mem_we     controller -> memory  write qualifier for mem_req
//   mem_addr   controller -> memory  captured byte address
//   mem_wdata  controller -> memory  captured store data
//   mem_ack    memory -> controller  single-cycle completion strobe
//   mem_rdata  memory -> controller  load data, valid while mem_ack=1
// Modports: master (controller side), slave (memory side).

interface data_mem_ctrl_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  mem_req;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_ack;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - load/store controller between a CPU datapath and external data memory
//
// Purpose: turns MemRead/MemWrite from the control unit into one request on the
// memory bus, stalls the pipeline while the access is in flight, bounds the wait
// for mem_ack with a timeout, and keeps sticky misalignment / bus-timeout flags.
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-high reset
//   MemWrite   in   store request
//   MemRead    in   load request
//   ALUOut     in   byte address
//   WriteData  in   store data
//   ReadData   out  load data to the result mux (holds between loads)
//   Stall      out  freezes PC and register-file write while high
//   AddrErr    out  sticky misaligned-access flag
//   BusErr     out  sticky timed-out-access flag
//   mem        master side of data_mem_ctrl_if (mem_req/we/addr/wdata, mem_ack/rdata)

module data_mem_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  MemWrite,
    input  logic                  MemRead,
    input  logic [DATA_WIDTH-1:0] ALUOut,
    input  logic [DATA_WIDTH-1:0] WriteData,
    output logic [DATA_WIDTH-1:0] ReadData,
    output logic                  Stall,
    output logic                  AddrErr,
    output logic                  BusErr,
    data_mem_ctrl_if.master       mem
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int                 CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [DATA_WIDTH-1:0] BUS_ERR_DATA = DATA_WIDTH'(32'hDEADBEEF);

    state_t                state_q, state_d;
    logic                  req_q, req_d;
    logic                  we_q, we_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  addr_err_q, addr_err_d;
    logic                  bus_err_q, bus_err_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic acc;
    logic aligned;

    assign acc     = MemRead | MemWrite;
    assign aligned = (ALUOut[1:0] == 2'b00);

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        addr_err_d = addr_err_q;
        bus_err_d  = bus_err_q;
        cnt_d      = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (acc) begin
                    if (aligned) begin
                        addr_d  = ALUOut;
                        wdata_d = WriteData;
                        // A simultaneous read+write request is treated as a store.
                        we_d    = MemWrite;
                        cnt_d   = '0;
                        req_d   = 1'b1;
                        state_d = S_REQ;
                    end else begin
                        addr_err_d = 1'b1;
                    end
                end
            end

            S_REQ: begin
                if (mem.mem_ack) begin
                    if (!we_q) begin
                        rdata_d = mem.mem_rdata;
                    end
                    req_d   = 1'b0;
                    state_d = S_DONE;
                end else begin
                    // Saturating increment: the counter must never wrap back into range.
                    cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
                    // cnt_q counts completed un-acked REQ cycles, so this fires on the
                    // TIMEOUT-th REQ cycle.
                    if (cnt_q == CNT_LAST) begin
                        bus_err_d = 1'b1;
                        if (!we_q) begin
                            rdata_d = BUS_ERR_DATA;
                        end
                        req_d   = 1'b0;
                        state_d = S_DONE;
                    end
                end
            end

            // DONE is the commit cycle; it never starts a new access.
            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                req_d   = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            addr_err_q <= 1'b0;
            bus_err_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            addr_err_q <= addr_err_d;
            bus_err_q  <= bus_err_d;
            cnt_q      <= cnt_d;
        end
    end

    // Stall rises in the detect cycle itself so the PC freezes before the request starts.
    assign Stall = ((state_q == S_IDLE) && acc && aligned) || (state_q == S_REQ);

    assign ReadData      = rdata_q;
    assign AddrErr       = addr_err_q;
    assign BusErr        = bus_err_q;
    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb/tb_data_mem_ctrl.sv - scoreboard testbench for data_mem_ctrl

module tb_data_mem_ctrl;

    localparam int DW = 32;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          MemWrite = 1'b0;
    logic          MemRead = 1'b0;
    logic [DW-1:0] ALUOut = '0;
    logic [DW-1:0] WriteData = '0;
    logic [DW-1:0] ReadData;
    logic          Stall;
    logic          AddrErr;
    logic          BusErr;

    data_mem_ctrl_if #(.DATA_WIDTH(DW)) bus ();

    data_mem_ctrl #(.DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .MemRead   (MemRead),
        .ALUOut    (ALUOut),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .Stall     (Stall),
        .AddrErr   (AddrErr),
        .BusErr    (BusErr),
        .mem       (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] addr;
        logic [DW-1:0] wdata;
        logic          we;
    } req_t;

    req_t          req_q[$];
    int            done_q[$];
    logic [DW-1:0] exp_rd = '0;
    logic          exp_ae = 1'b0;
    logic          exp_be = 1'b0;
    int            vectors = 0;
    int            miscompares = 0;
    int            stall_cnt = 0;
    int            req_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares observed bus/flag behaviour against the model and queues.
    initial begin : monitor
        req_t cur;
        logic prev_req;
        int   k;
        cur      = '0;
        prev_req = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                chk("rst_mem_req",   64'(bus.mem_req), 64'd0);
                chk("rst_mem_we",    64'(bus.mem_we), 64'd0);
                chk("rst_mem_addr",  64'(bus.mem_addr), 64'd0);
                chk("rst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
                chk("rst_read_data", 64'(ReadData), 64'd0);
                chk("rst_addr_err",  64'(AddrErr), 64'd0);
                chk("rst_bus_err",   64'(BusErr), 64'd0);
                prev_req  = 1'b0;
                stall_cnt = 0;
                req_cnt   = 0;
            end else begin
                chk("read_data", 64'(ReadData), 64'(exp_rd));
                chk("addr_err",  64'(AddrErr), 64'(exp_ae));
                chk("bus_err",   64'(BusErr), 64'(exp_be));
                if (Stall) stall_cnt++;
                if (bus.mem_req) begin
                    if (!prev_req) begin
                        chk("req_expected", 64'(req_q.size() != 0), 64'd1);
                        if (req_q.size() != 0) cur = req_q.pop_front();
                    end
                    req_cnt++;
                    chk("mem_addr",  64'(bus.mem_addr), 64'(cur.addr));
                    chk("mem_wdata", 64'(bus.mem_wdata), 64'(cur.wdata));
                    chk("mem_we",    64'(bus.mem_we), 64'(cur.we));
                end else if (prev_req) begin
                    chk("done_expected", 64'(done_q.size() != 0), 64'd1);
                    if (done_q.size() != 0) begin
                        k = done_q.pop_front();
                        chk("req_cycles",   64'(req_cnt), 64'(k));
                        chk("stall_cycles", 64'(stall_cnt), 64'(k + 1));
                    end
                    chk("stall_in_done", 64'(Stall), 64'd0);
                    stall_cnt = 0;
                    req_cnt   = 0;
                end
                prev_req = bus.mem_req;
            end
        end
    end

    // One control-unit access plus the memory's response. ack_delay >= TO means no ack.
    task automatic do_access(input logic rd, input logic wr, input logic [DW-1:0] addr,
                             input logic [DW-1:0] wdata, input int ack_delay,
                             input logic [DW-1:0] rdata);
        int k;
        @(posedge clk); #1;
        MemRead     = rd;
        MemWrite    = wr;
        ALUOut      = addr;
        WriteData   = wdata;
        bus.mem_ack = 1'b0;
        if (!(rd | wr)) begin
            return;
        end
        if (addr[1:0] != 2'b00) begin
            @(posedge clk); #1;
            exp_ae   = 1'b1;
            MemRead  = 1'b0;
            MemWrite = 1'b0;
            return;
        end
        k = (ack_delay < TO) ? ack_delay + 1 : TO;
        req_q.push_back('{addr: addr, wdata: wdata, we: wr});
        done_q.push_back(k);
        for (int i = 0; i < k; i++) begin
            @(posedge clk); #1;
            bus.mem_ack   = (i == ack_delay);
            bus.mem_rdata = (i == ack_delay) ? rdata : DW'($urandom);
        end
        @(posedge clk); #1;
        if (!wr) exp_rd = (ack_delay < TO) ? rdata : 32'hDEADBEEF;
        if (ack_delay >= TO) exp_be = 1'b1;
        // Requests stay high through DONE and a stray ack arrives: neither may start anything.
        bus.mem_ack   = 1'($urandom_range(0, 1));
        bus.mem_rdata = DW'($urandom);
        @(posedge clk); #1;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        bus.mem_ack = 1'($urandom_range(0, 1));
    endtask

    task automatic reset_mid_req();
        @(posedge clk); #1;
        MemRead     = 1'b1;
        MemWrite    = 1'b0;
        ALUOut      = 32'h20;
        bus.mem_ack = 1'b0;
        req_q.push_back('{addr: 32'h20, wdata: WriteData, we: 1'b0});
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_reset_req", 64'(bus.mem_req), 64'd1);
        reset   = 1'b1;
        exp_rd  = '0;
        exp_ae  = 1'b0;
        exp_be  = 1'b0;
        MemRead = 1'b0;
        #1;
        chk("async_req_drop", 64'(bus.mem_req), 64'd0);
        chk("async_read_data", 64'(ReadData), 64'd0);
        @(posedge clk); #1;
        reset         = 1'b0;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h0BADF00D;
        repeat (3) @(posedge clk);
        #1;
        bus.mem_ack = 1'b0;
    endtask

    initial begin : stimulus
        logic          rd, wr;
        logic [DW-1:0] addr;
        int            dly;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        do_access(1'b1, 1'b0, 32'h40, 32'h0, 0, 32'h12345678);
        do_access(1'b0, 1'b1, 32'h44, 32'hCAFEF00D, 2, 32'h55555555);
        do_access(1'b1, 1'b0, 32'h42, 32'h0, 0, 32'h0);
        do_access(1'b1, 1'b0, 32'h10, 32'h0, 99, 32'h0);
        do_access(1'b1, 1'b1, 32'h08, 32'hA5A5A5A5, 1, 32'h77777777);
        do_access(1'b1, 1'b0, 32'h0C, 32'h0, TO - 1, 32'h13579BDF);
        reset_mid_req();
        do_access(1'b1, 1'b0, 32'h30, 32'h0, 3, 32'h2468ACE0);

        for (int n = 0; n < 80; n++) begin
            rd   = 1'($urandom_range(0, 1));
            wr   = 1'($urandom_range(0, 1));
            addr = DW'($urandom) & 32'hFFFF_FFFC;
            if ($urandom_range(0, 4) == 0) addr = addr | DW'($urandom_range(1, 3));
            dly  = $urandom_range(0, TO + 2);
            do_access(rd, wr, addr, DW'($urandom), dly, DW'($urandom));
        end

        repeat (3) @(posedge clk);
        #1;
        chk("queues_drained", 64'(req_q.size() + done_q.size()), 64'd0);
        chk("stall_leftover", 64'(stall_cnt), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the data and address width.
REQ-002 Parameter TIMEOUT, default 15, SHALL set the maximum number of REQ cycles spent waiting for mem_ack.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset  in  1  asynchronous, active-high.
REQ-006 MemWrite  in  1  store request from the control unit.
REQ-007 MemRead  in  1  load request from the control unit.
REQ-008 ALUOut  in  DATA_WIDTH  byte address from the datapath ALU.
REQ-009 WriteData  in  DATA_WIDTH  store data from register-file port RD2.
REQ-010 ReadData  out  DATA_WIDTH  load data returned to the datapath result mux.
REQ-011 Stall  out  1  freezes the PC and register-file write while high.
REQ-012 AddrErr  out  1  sticky flag for a misaligned access.
REQ-013 BusErr  out  1  sticky flag for a timed-out access.
REQ-014 mem_req  out  1  request to external memory.
REQ-015 mem_we  out  1  write qualifier for mem_req.
REQ-016 mem_addr  out  DATA_WIDTH  captured address.
REQ-017 mem_wdata  out  DATA_WIDTH  captured store data.
REQ-018 mem_ack  in  1  single-cycle completion strobe from memory.
REQ-019 mem_rdata  in  DATA_WIDTH  load data, valid while mem_ack=1.

Function
REQ-020 The FSM SHALL have three states: IDLE, REQ and DONE.
REQ-021 The access condition SHALL be acc = MemRead|MemWrite; an access is aligned when ALUOut[1:0]==2'b00.
REQ-022 IDLE, aligned acc: capture ALUOut into mem_addr, WriteData into mem_wdata and MemWrite into mem_we; clear the timeout counter; go to REQ.
REQ-023 IDLE, misaligned acc: issue no request, set AddrErr, stay in IDLE, leave Stall low.
REQ-024 When MemRead and MemWrite are both high, the access SHALL be a write.
REQ-025 mem_req SHALL be 1 exactly while in REQ; mem_addr, mem_wdata and mem_we SHALL hold stable throughout REQ.
REQ-026 REQ with mem_ack=1: on a read, load mem_rdata into ReadData; go to DONE.
REQ-027 REQ with mem_ack=0: increment the counter; when the counter equals TIMEOUT-1, set BusErr, load ReadData with 32'hDEADBEEF on a read, and go to DONE.
REQ-028 DONE SHALL return to IDLE unconditionally and never start a new access, even while MemRead/MemWrite are still high.
REQ-029 Stall SHALL be combinational: (IDLE & acc & aligned) | REQ. Stall is low in DONE so the PC and register file commit at the end of DONE.
REQ-030 mem_ack received in IDLE or DONE SHALL be ignored.
REQ-031 ReadData SHALL change only per REQ-026 and REQ-027 and otherwise hold.
REQ-032 Load latency from the IDLE detect cycle to ReadData valid SHALL be k+1 clocks, where k = number of REQ cycles (k>=1).
REQ-033 The timeout counter SHALL be $clog2(TIMEOUT+1) bits wide and SHALL saturate, never wrap.

Reset
REQ-034 Asserting reset SHALL immediately force: state IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, ReadData=0, AddrErr=0, BusErr=0, counter=0.
REQ-035 Reset during REQ SHALL drop mem_req asynchronously; a later mem_ack SHALL be ignored.
REQ-036 AddrErr and BusErr SHALL clear only on reset.

Verification
REQ-037 Load, ALUOut=0x40, ack in first REQ cycle with mem_rdata=0x12345678 -> Stall high 2 cycles; ReadData=0x12345678 in DONE; mem_req high 1 cycle.
REQ-038 Store, ALUOut=0x44, WriteData=0xCAFEF00D, ack after 3 REQ cycles -> mem_we=1, mem_addr=0x44, mem_wdata=0xCAFEF00D stable for 3 cycles; Stall high 4 cycles; ReadData unchanged.
REQ-039 Load, ALUOut=0x42 -> mem_req never asserted; Stall=0; AddrErr=1 and stays 1 until reset.
REQ-040 Load with no ack, TIMEOUT=15 -> mem_req high 15 cycles; then BusErr=1, ReadData=0xDEADBEEF, return to IDLE.
REQ-041 MemRead=MemWrite=1, ALUOut=0x8 -> write access (mem_we=1); stray mem_ack in IDLE -> no state change.
REQ-042 Reset asserted mid-REQ -> mem_req=0 before the next clock edge; all outputs at reset values; ack after release ignored.
